// File: rtl/stream_filter_pkg.sv
// stream_filter_pkg: cfg addresses, driver FSM states and rescale field layout.
// The FLUSH state exists only when STREAM_FILTER_DRIVER_FLUSH_EN is defined.
package stream_filter_pkg;
    localparam int CFG_WIDTH = 1;
    localparam int CFG_KERNEL = 2;
    localparam int CFG_RESCALE = 3;
    localparam int SHIFT_LSB = 8;
    localparam int HEAD_LSB = 0;
    typedef enum logic [2:0] {
        IDLE,
        WR_WIDTH,
        WR_KERNEL,
        WR_RESCALE,
        STREAM,
`ifdef STREAM_FILTER_DRIVER_FLUSH_EN
        FLUSH,
`endif
        FINISH
    } state_t;
endpackage

// File: rtl/stream_filter_driver_cfg_writer.sv
// cfg_writer: after a start pulse, emits width, KER_NB kernel and rescale writes on back-to-back cycles.
module cfg_writer
    import stream_filter_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int MEM_AWIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int KER_NB = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [MEM_AWIDTH-1:0]      width,
    input  logic [KER_WIDTH*KER_NB-1:0] kernel,
    input  logic [7:0]                 shift,
    input  logic [7:0]                 head,
    output logic [CFG_DWIDTH-1:0]      cfg_data,
    output logic [CFG_AWIDTH-1:0]      cfg_addr,
    output logic                       cfg_valid,
    output logic                       kernel_last,
    output logic                       done
);
    localparam int NW = KER_NB + 2;
    localparam int IW = $clog2(NW);
    logic            active;
    logic [IW-1:0]   idx;
    logic [KER_WIDTH-1:0] coef;
    logic [CFG_DWIDTH-1:0] wdata;
    logic [CFG_AWIDTH-1:0] waddr;
    logic            first;
    logic            last;
    // idx is the write prepared this cycle: 0 width, 1..KER_NB kernel, last rescale
    assign first = idx == '0;
    assign last = idx == IW'(NW - 1);
    assign kernel_last = active && idx == IW'(KER_NB);
    always_comb begin
        coef = '0;
        for (int k = 0; k < KER_NB; k++)
            if (idx == IW'(k + 1)) coef = kernel[k*KER_WIDTH +: KER_WIDTH];
        waddr = first ? CFG_AWIDTH'(CFG_WIDTH) : last ? CFG_AWIDTH'(CFG_RESCALE) : CFG_AWIDTH'(CFG_KERNEL);
        wdata = first ? CFG_DWIDTH'(width)
              : last ? (CFG_DWIDTH'(shift) << SHIFT_LSB) | (CFG_DWIDTH'(head) << HEAD_LSB)
              : CFG_DWIDTH'(coef);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            idx <= '0;
            cfg_valid <= 1'b0;
            cfg_addr <= '0;
            cfg_data <= '0;
            done <= 1'b0;
        end else begin
            cfg_valid <= active;
            cfg_addr <= active ? waddr : '0;
            cfg_data <= active ? wdata : '0;
            done <= active && last;
            if (start) begin
                active <= 1'b1;
                idx <= '0;
            end else if (active) begin
                idx <= last ? '0 : idx + 1'b1;
                active <= !last;
            end
        end
    end
endmodule

// File: rtl/stream_filter_driver.sv
// stream_filter_driver: configures the 3x3 filter over cfg, then forwards a frame of pixels.
// Define STREAM_FILTER_DRIVER_FLUSH_EN to append width+2 zero pixels that drain the line delays.
module stream_filter_driver
    import stream_filter_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int MEM_AWIDTH = 16,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int KER_NB = 9,
    parameter int CNT_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [MEM_AWIDTH-1:0]       set_width,
    input  logic [KER_WIDTH*KER_NB-1:0] set_kernel,
    input  logic [7:0]                  set_shift,
    input  logic [7:0]                  set_head,
    input  logic [CNT_WIDTH-1:0]        set_pixels,
    input  logic [IMG_WIDTH-1:0]        up_data,
    input  logic                        up_val,
    output logic                        up_rdy,
    output logic [CFG_DWIDTH-1:0]       cfg_data,
    output logic [CFG_AWIDTH-1:0]       cfg_addr,
    output logic                        cfg_valid,
    output logic [IMG_WIDTH-1:0]        image,
    output logic                        image_val,
    output logic                        busy,
    output logic                        done
);
    state_t state, state_n;
    logic [MEM_AWIDTH-1:0]       width_q;
    logic [KER_WIDTH*KER_NB-1:0] kernel_q;
    logic [7:0]                  shift_q;
    logic [7:0]                  head_q;
    logic [CNT_WIDTH-1:0]        pix_q;
    logic [CNT_WIDTH-1:0]        cnt;
    logic accept;
    logic xfer;
    logic frame_end;
    logic kernel_last;
    logic wr_done;
    assign accept = state == IDLE && start;
    assign frame_end = cnt == pix_q;
    assign up_rdy = state == STREAM && !frame_end;
    assign xfer = up_val && up_rdy;
    assign busy = state != IDLE;
    assign done = state == FINISH;
`ifdef STREAM_FILTER_DRIVER_FLUSH_EN
    logic [MEM_AWIDTH:0] fcnt;
    logic flush_last;
    assign flush_last = fcnt == {1'b0, width_q} + 1'b1;
`endif
    cfg_writer #(
        .CFG_DWIDTH(CFG_DWIDTH),
        .CFG_AWIDTH(CFG_AWIDTH),
        .MEM_AWIDTH(MEM_AWIDTH),
        .KER_WIDTH(KER_WIDTH),
        .KER_NB(KER_NB)
    ) u_cfg_writer (
        .clk(clk),
        .rst(rst),
        .start(accept),
        .width(width_q),
        .kernel(kernel_q),
        .shift(shift_q),
        .head(head_q),
        .cfg_data(cfg_data),
        .cfg_addr(cfg_addr),
        .cfg_valid(cfg_valid),
        .kernel_last(kernel_last),
        .done(wr_done)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = start ? WR_WIDTH : IDLE;
            WR_WIDTH:   state_n = WR_KERNEL;
            WR_KERNEL:  state_n = kernel_last ? WR_RESCALE : WR_KERNEL;
            WR_RESCALE: state_n = !wr_done ? WR_RESCALE : pix_q != '0 ? STREAM : FINISH;
`ifdef STREAM_FILTER_DRIVER_FLUSH_EN
            STREAM:     state_n = frame_end ? FLUSH : STREAM;
            FLUSH:      state_n = flush_last ? FINISH : FLUSH;
`else
            STREAM:     state_n = frame_end ? FINISH : STREAM;
`endif
            FINISH:     state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            width_q <= '0;
            kernel_q <= '0;
            shift_q <= '0;
            head_q <= '0;
            pix_q <= '0;
            cnt <= '0;
            image <= '0;
            image_val <= 1'b0;
`ifdef STREAM_FILTER_DRIVER_FLUSH_EN
            fcnt <= '0;
`endif
        end else begin
            state <= state_n;
            image <= xfer ? up_data : '0;
            image_val <= xfer;
            if (accept) begin
                width_q <= set_width;
                kernel_q <= set_kernel;
                shift_q <= set_shift;
                head_q <= set_head;
                pix_q <= set_pixels;
                cnt <= '0;
            end else if (xfer) begin
                cnt <= cnt + 1'b1;
            end
`ifdef STREAM_FILTER_DRIVER_FLUSH_EN
            fcnt <= state == FLUSH ? fcnt + 1'b1 : '0;
            if (state == FLUSH) image_val <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_stream_filter_driver.sv
// tb_stream_filter_driver: directed steps with cfg-write and pixel scoreboards for stream_filter_driver.
module tb_stream_filter_driver;
    localparam int CFG_DWIDTH = 32;
    localparam int CFG_AWIDTH = 5;
    localparam int MEM_AWIDTH = 16;
    localparam int IMG_WIDTH = 16;
    localparam int KER_WIDTH = 16;
    localparam int KER_NB = 9;
    localparam int CNT_WIDTH = 24;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [MEM_AWIDTH-1:0] set_width = '0;
    logic [KER_WIDTH*KER_NB-1:0] set_kernel = '0;
    logic [7:0] set_shift = '0;
    logic [7:0] set_head = '0;
    logic [CNT_WIDTH-1:0] set_pixels = '0;
    logic [IMG_WIDTH-1:0] up_data = '0;
    logic up_val = 1'b0;
    logic up_rdy;
    logic [CFG_DWIDTH-1:0] cfg_data;
    logic [CFG_AWIDTH-1:0] cfg_addr;
    logic cfg_valid;
    logic [IMG_WIDTH-1:0] image;
    logic image_val;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    stream_filter_driver #(
        .CFG_DWIDTH(CFG_DWIDTH), .CFG_AWIDTH(CFG_AWIDTH), .MEM_AWIDTH(MEM_AWIDTH),
        .IMG_WIDTH(IMG_WIDTH), .KER_WIDTH(KER_WIDTH), .KER_NB(KER_NB), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .set_width(set_width), .set_kernel(set_kernel),
        .set_shift(set_shift), .set_head(set_head), .set_pixels(set_pixels),
        .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .image(image), .image_val(image_val), .busy(busy), .done(done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n = 0;
    int done_cyc = -1;
    int done_cnt = 0;
    int rdy_cnt = 0;
    int img_cnt = 0;
    int last_img = -1;
    int d0, r0, i0;
    bit toggle = 1'b0;
    bit vphase = 1'b1;
    logic [CFG_AWIDTH+CFG_DWIDTH-1:0] cfg_q[$];
    logic [IMG_WIDTH-1:0] img_q[$];
    logic [IMG_WIDTH-1:0] src[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        up_val = src.size() > 0 && (!toggle || vphase);
        up_data = src.size() > 0 ? src[0] : '0;
    endtask

    task automatic cycle();
        logic take;
        take = up_val && up_rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (take) void'(src.pop_front());
        vphase = !vphase;
        drive();
        if (cfg_valid) begin
            if (cfg_q.size() == 0) chk("cfg_extra", 64'(cfg_valid), 0);
            else chk("cfg_write", {cfg_addr, cfg_data}, cfg_q.pop_front());
        end
        if (image_val) begin
            if (img_q.size() == 0) chk("img_extra", 64'(image_val), 0);
            else chk("image", 64'(image), 64'(img_q.pop_front()));
            img_cnt++;
            last_img = cyc;
        end
        if (up_rdy) rdy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic load(int w, int kb, int sh, int hd, int px);
        set_width = MEM_AWIDTH'(w);
        for (int k = 0; k < KER_NB; k++) set_kernel[k*KER_WIDTH +: KER_WIDTH] = KER_WIDTH'(kb + k);
        set_shift = 8'(sh);
        set_head = 8'(hd);
        set_pixels = CNT_WIDTH'(px);
        cfg_q.push_back({CFG_AWIDTH'(1), CFG_DWIDTH'(w)});
        for (int k = 0; k < KER_NB; k++) cfg_q.push_back({CFG_AWIDTH'(2), CFG_DWIDTH'(kb + k)});
        cfg_q.push_back({CFG_AWIDTH'(3), CFG_DWIDTH'(sh * 256 + hd)});
    endtask

    task automatic feed(int base, int cnt);
        for (int i = 0; i < cnt; i++) begin
            src.push_back(IMG_WIDTH'(base + i));
            img_q.push_back(IMG_WIDTH'(base + i));
        end
        drive();
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        n = cyc;
        start = 1'b0;
        set_width = '1;
        set_kernel = '1;
        set_shift = 8'hff;
        set_head = 8'hff;
        set_pixels = CNT_WIDTH'(77);
        d0 = done_cnt;
        r0 = rdy_cnt;
        i0 = img_cnt;
    endtask

    task automatic wait_done(int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) cycle();
        chk("done_seen", 64'(done_cnt), 64'(d0 + 1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {cfg_valid, cfg_addr, cfg_data, image, image_val, up_rdy, busy, done}, '0);
        rst = 1'b1;
        cycle();
        // frame of 4, settings scrambled right after start
        load(640, 1, 4, 2, 4);
        feed(100, 4);
        do_start();
        chk("busy_start", 64'(busy), 1);
        for (int i = 0; i < 11; i++) begin
            cycle();
            chk("cfg_back_to_back", 64'(cfg_valid), 1);
        end
        wait_done(60);
        chk("done_after_last_pixel", 64'(done_cyc - last_img), 1);
        chk("t1_pixels", 64'(img_cnt - i0), 4);
        cycle();
        chk("busy_after_done", 64'(busy), 0);
        // constant up_val, 5 pixels
        load(320, 30, 1, 0, 5);
        feed(10, 5);
        do_start();
        wait_done(60);
        chk("t2_rdy_cycles", 64'(rdy_cnt - r0), 5);
        chk("t2_pixels", 64'(img_cnt - i0), 5);
        chk("t2_last_img_edge", 64'(last_img - n), 17);
        cycle();
        // gapped up_val, 3 pixels
        toggle = 1'b1;
        load(64, 200, 3, 7, 3);
        feed(7, 3);
        do_start();
        wait_done(80);
        chk("t3_pixels", 64'(img_cnt - i0), 3);
        chk("t3_src_drained", 64'(src.size()), 0);
        toggle = 1'b0;
        cycle();
        // zero-pixel frame skips STREAM
        load(8, 1000, 0, 255, 0);
        do_start();
        wait_done(40);
        chk("t4_done_edge", 64'(done_cyc - n), 12);
        chk("t4_no_rdy", 64'(rdy_cnt - r0), 0);
        cycle();
        // reset after the 5th kernel write
        load(33, 20, 1, 5, 2);
        do_start();
        repeat (6) cycle();
        rst = 1'b0;
        #1;
        chk("abort_outputs", {cfg_valid, cfg_addr, cfg_data, image, image_val, up_rdy, busy, done}, '0);
        cfg_q.delete();
        repeat (3) cycle();
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        rst = 1'b1;
        cycle();
        load(33, 20, 1, 5, 2);
        feed(1, 2);
        do_start();
        cycle();
        chk("replay_width_addr", 64'(cfg_addr), 1);
        wait_done(60);
        chk("replay_pixels", 64'(img_cnt - i0), 2);
        cycle();
        // start held through the sequence and the done cycle
        load(5, 50, 7, 9, 0);
        start = 1'b1;
        cycle();
        n = cyc;
        repeat (11) cycle();
        cycle();
        chk("held_done_n12", 64'(done), 1);
        cycle();
        chk("held_idle_after_done", 64'(busy), 0);
        load(5, 50, 7, 9, 0);
        d0 = done_cnt;
        cycle();
        chk("held_restart", 64'(busy), 1);
        start = 1'b0;
        n = cyc;
        cycle();
        chk("restart_first_write", 64'(cfg_valid), 1);
        wait_done(40);
        chk("restart_done_edge", 64'(done_cyc - n), 12);
        chk("cfg_q_empty", 64'(cfg_q.size()), 0);
        chk("img_q_empty", 64'(img_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_filter_driver.md
Name: stream_filter_driver

Overview:
Upstream master for the streaming 3x3 filter. On a start pulse it emits the filter's configuration write sequence on the cfg bus: line width, nine kernel coefficients, then rescale shift/head. It then forwards a fixed number of image pixels from a ready/valid source onto the filter's image/image_val input. It sits between a host or test sequencer and the filter wrapper.

Parameters:
CFG_DWIDTH, 32, cfg bus data width
CFG_AWIDTH, 5, cfg bus address width
MEM_AWIDTH, 16, line-width (delay) field width
IMG_WIDTH, 16, pixel width
KER_WIDTH, 16, kernel coefficient width
KER_NB, 9, number of kernel coefficients (3x3)
CNT_WIDTH, 24, frame pixel counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin sequence; sampled only in IDLE
set_width  in  MEM_AWIDTH  image line width
set_kernel  in  KER_WIDTH*KER_NB  coefficients, coeff k at bits [k*KER_WIDTH +: KER_WIDTH]
set_shift  in  8  rescale shift
set_head  in  8  rescale head
set_pixels  in  CNT_WIDTH  pixels to forward this frame
up_data  in  IMG_WIDTH  source pixel
up_val  in  1  source valid
up_rdy  out  1  source ready
cfg_data  out  CFG_DWIDTH  cfg write data
cfg_addr  out  CFG_AWIDTH  cfg write address
cfg_valid  out  1  cfg write strobe
image  out  IMG_WIDTH  pixel to filter
image_val  out  1  pixel valid
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; counters 0. Reset asserted mid-sequence aborts the sequence with no done pulse.
- Shared constants: CFG_WIDTH=1, CFG_KERNEL=2, CFG_RESCALE=3.
- FSM states: IDLE, WR_WIDTH, WR_KERNEL, WR_RESCALE, STREAM, FINISH.
- IDLE: start=1 latches all set_* inputs, sets busy=1, and moves to WR_WIDTH. While busy, start is ignored.
- Cycle timing, with start seen high at edge N:
  - Edge N+1: cfg_valid=1, cfg_addr=1, cfg_data = set_width zero-extended.
  - Edges N+2..N+10: cfg_addr=2, coefficients 0..8 in index order, each zero-extended.
  - Edge N+11: cfg_addr=3, cfg_data = {zeros, shift[7:0] at bits 15:8, head at bits 7:0}.
- Outside a write cycle, cfg_valid, cfg_addr and cfg_data are all 0. Writes are back-to-back with no gaps.
- STREAM:
  - up_rdy = (state==STREAM) & (remaining>0). up_rdy is derived from registered state only, never from up_val.
  - Transfer = up_val & up_rdy. Registered output: image <= up_data, image_val <= 1 on the cycle after a transfer; otherwise image=0, image_val=0.
  - The pixel counter increments per transfer. On reaching set_pixels, up_rdy drops the next cycle and the FSM enters FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 from the following cycle, then return to IDLE. start in the done cycle is ignored; start in the next cycle is accepted.
- set_pixels=0: STREAM is skipped. FINISH follows WR_RESCALE directly and up_rdy never asserts.
- up_val gaps stall the count; there is no timeout.
- Latched settings are immune to set_* changes after start.

Optional Feature:
Macro STREAM_FILTER_DRIVER_FLUSH_EN.
- Defined: after the last frame pixel, the FSM enters an extra FLUSH state. It emits set_width+2 zero pixels (image=0, image_val=1) back-to-back with up_rdy=0, draining the filter's line delays, then enters FINISH.
- Undefined: no FLUSH state; STREAM goes directly to FINISH.

Decomposition:
- Package stream_filter_pkg holds: CFG_WIDTH/CFG_KERNEL/CFG_RESCALE address constants, the FSM state enum, and the rescale field bit positions (SHIFT_LSB=8, HEAD_LSB=0).
- One natural sub-module, cfg_writer: serialises the 11 writes (width, 9 kernel, rescale) from the latched settings, with a start/done handshake to the top FSM.

Test Plan:
- Reset, then start with width=640, kernel k=k+1, shift=4, head=2, pixels=4 -> cfg writes at edges N+1..N+11: (1,640), (2,1)..(2,9), (3,0x0402); done 1 cycle after the 4th image_val; busy low afterwards.
- up_val constantly high with pixels=5 data 10..14 -> image_val high 5 consecutive cycles carrying 10..14, up_rdy high exactly 5 cycles.
- up_val toggling 1,0,1,0 with pixels=3 -> image 3 pulses matching source order; count unaffected by gaps.
- pixels=0 -> 11 cfg writes, up_rdy never high, done at edge N+12.
- rst pulled low after the 5th kernel write -> all outputs 0 immediately, no done; a new start then replays the full sequence from the width write.
- start re-asserted while busy and in the done cycle -> ignored; start one cycle after done -> new sequence begins.
